// File: rtl/ctrl_pipe.sv
// RV32I decode plus a STAGES-deep control pipeline with valid/stall/flush and load-use bubbles.
// One-cycle decode-to-stage-0 latency; stall_in freezes every stage, and hazards or flushes refuse ID.
package rv32i_types;
  localparam logic [6:0] op_lui   = 7'b0110111;
  localparam logic [6:0] op_auipc = 7'b0010111;
  localparam logic [6:0] op_jal   = 7'b1101111;
  localparam logic [6:0] op_jalr  = 7'b1100111;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;

  localparam logic [2:0] alu_add = 3'b000;
  localparam logic [2:0] alu_sll = 3'b001;
  localparam logic [2:0] alu_sra = 3'b010;
  localparam logic [2:0] alu_sub = 3'b011;
  localparam logic [2:0] alu_xor = 3'b100;
  localparam logic [2:0] alu_srl = 3'b101;
  localparam logic [2:0] alu_or  = 3'b110;
  localparam logic [2:0] alu_and = 3'b111;

  localparam logic [2:0] f3_add  = 3'b000;
  localparam logic [2:0] f3_slt  = 3'b010;
  localparam logic [2:0] f3_sltu = 3'b011;
  localparam logic [2:0] f3_sr   = 3'b101;

  localparam logic [2:0] br_blt  = 3'b100;
  localparam logic [2:0] br_bltu = 3'b110;

  localparam logic       mux1_rs1 = 1'b0;
  localparam logic       mux1_pc  = 1'b1;

  localparam logic [2:0] mux2_i_imm = 3'd0;
  localparam logic [2:0] mux2_u_imm = 3'd1;
  localparam logic [2:0] mux2_b_imm = 3'd2;
  localparam logic [2:0] mux2_s_imm = 3'd3;
  localparam logic [2:0] mux2_j_imm = 3'd4;
  localparam logic [2:0] mux2_rs2   = 3'd5;

  localparam logic [2:0] rf_alu_out  = 3'd0;
  localparam logic [2:0] rf_br_en    = 3'd1;
  localparam logic [2:0] rf_u_imm    = 3'd2;
  localparam logic [2:0] rf_load     = 3'd3;
  localparam logic [2:0] rf_pc_plus4 = 3'd4;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic       cmpmux_sel;
    logic       pcmux_sel;
    logic [2:0] regfilemux_sel;
    logic [2:0] funct3;
    logic       is_branch;
    logic       mem_read;
    logic       mem_write;
    logic       load_regfile;
  } rv32i_control_word;
endpackage

module ctrl_pipe
  import rv32i_types::*;
#(
  parameter int STAGES       = 3,
  parameter bit RS_BYPASS_X0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  id_ready,
  output logic                  hazard_stall,
  output logic                  illegal,
  output rv32i_control_word     ex_ctrl,
  output logic [STAGES-1:0]     stage_valid,
  output logic [5*STAGES-1:0]   stage_rd,
  output logic [STAGES-1:0]     stage_wr
);

  logic [6:0] id_opc;
  logic [2:0] id_f3;
  logic [6:0] id_f7;
  logic [4:0] id_rd, id_rs1, id_rs2;
  assign id_opc = id_instr[6:0];
  assign id_rd  = id_instr[11:7];
  assign id_f3  = id_instr[14:12];
  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];
  assign id_f7  = id_instr[31:25];

  rv32i_control_word dec;
  logic dec_ill, use_rs1, use_rs2, is_reg;

  always_comb begin
    dec          = '0;
    dec_ill      = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    is_reg       = (id_opc == op_reg);
    dec.opcode   = id_opc;
    dec.funct3   = id_f3;
    case (id_opc)
      op_lui: begin
        dec.alumux2_sel = mux2_u_imm; dec.regfilemux_sel = rf_u_imm; dec.load_regfile = 1'b1;
      end
      op_auipc: begin
        dec.alumux1_sel = mux1_pc; dec.alumux2_sel = mux2_u_imm; dec.load_regfile = 1'b1;
      end
      op_jal: begin
        dec.alumux1_sel = mux1_pc; dec.alumux2_sel = mux2_j_imm; dec.pcmux_sel = 1'b1;
        dec.regfilemux_sel = rf_pc_plus4; dec.load_regfile = 1'b1;
      end
      op_jalr: begin
        dec.alumux1_sel = mux1_rs1; dec.alumux2_sel = mux2_i_imm; dec.pcmux_sel = 1'b1;
        dec.regfilemux_sel = rf_pc_plus4; dec.load_regfile = 1'b1; use_rs1 = 1'b1;
      end
      op_br: begin
        dec.is_branch = 1'b1; dec.cmpop = id_f3; dec.alumux1_sel = mux1_pc;
        dec.alumux2_sel = mux2_b_imm; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      op_load: begin
        dec.alumux2_sel = mux2_i_imm; dec.mem_read = 1'b1; dec.regfilemux_sel = rf_load;
        dec.load_regfile = 1'b1; use_rs1 = 1'b1;
      end
      op_store: begin
        dec.alumux2_sel = mux2_s_imm; dec.mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      op_imm, op_reg: begin
        // op_imm shifts carry the same funct7 in imm[11:5], so SRAI decodes like SRA
        dec_ill            = is_reg && (id_f7 != 7'b0000000) && (id_f7 != 7'b0100000);
        dec.aluop          = id_f3;
        dec.alumux2_sel    = is_reg ? mux2_rs2 : mux2_i_imm;
        dec.regfilemux_sel = rf_alu_out;
        dec.load_regfile   = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = is_reg;
        if (id_f3 == f3_add && is_reg && id_f7[5]) dec.aluop = alu_sub;
        if (id_f3 == f3_sr && id_f7[5])            dec.aluop = alu_sra;
        if (id_f3 == f3_slt || id_f3 == f3_sltu) begin
          dec.cmpop          = (id_f3 == f3_slt) ? br_blt : br_bltu;
          dec.cmpmux_sel     = ~is_reg;
          dec.regfilemux_sel = rf_br_en;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
    if (id_rd == 5'd0) dec.load_regfile = 1'b0;
  end

  logic [STAGES-1:0]      vld_q, vld_d, lr_q, lr_d;
  logic [STAGES-1:0][4:0] rd_q, rd_d;
  rv32i_control_word      ctrl0_q, ctrl0_d;
  logic                   ill_q, ill_d;
  logic                   hit_rs1, hit_rs2, accept;

  always_comb begin
    hit_rs1      = use_rs1 && (id_rs1 == rd_q[0]) && !(RS_BYPASS_X0 && id_rs1 == 5'd0);
    hit_rs2      = use_rs2 && (id_rs2 == rd_q[0]) && !(RS_BYPASS_X0 && id_rs2 == 5'd0);
    hazard_stall = id_valid && vld_q[0] && ctrl0_q.mem_read && (hit_rs1 || hit_rs2);
    id_ready     = !stall_in && !hazard_stall && !flush;
    accept       = id_valid && id_ready;
  end

  always_comb begin
    vld_d   = vld_q;
    lr_d    = lr_q;
    rd_d    = rd_q;
    ctrl0_d = ctrl0_q;
    ill_d   = ill_q;
    if (!stall_in) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        vld_d[k] = vld_q[k-1];
        lr_d[k]  = lr_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      // bubbles (hazard, flush, idle ID) enter stage 0 as all-zero entries
      vld_d[0] = accept;
      lr_d[0]  = accept && dec.load_regfile;
      rd_d[0]  = accept ? id_rd : 5'd0;
      ctrl0_d  = accept ? dec : '0;
      ill_d    = accept && dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      lr_q    <= '0;
      rd_q    <= '0;
      ctrl0_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      lr_q    <= lr_d;
      rd_q    <= rd_d;
      ctrl0_q <= ctrl0_d;
      ill_q   <= ill_d;
    end
  end

  assign ex_ctrl     = ctrl0_q;
  assign illegal     = vld_q[0] && ill_q;
  assign stage_valid = vld_q;
  assign stage_rd    = rd_q;
  assign stage_wr    = vld_q & lr_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe (STAGES=4): decode vector table, hand-written pipeline corner sequences,
// then random traffic compared against a per-stage reference model built from decode rules.
module tb_ctrl_pipe;
  import rv32i_types::*;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n, id_valid, stall_in, flush;
  logic [31:0] id_instr;
  logic id_ready, hazard_stall, illegal;
  rv32i_control_word ex_ctrl;
  logic [S-1:0] stage_valid, stage_wr;
  logic [5*S-1:0] stage_rd;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.STAGES(S), .RS_BYPASS_X0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .stall_in(stall_in), .flush(flush), .id_ready(id_ready),
    .hazard_stall(hazard_stall), .illegal(illegal), .ex_ctrl(ex_ctrl),
    .stage_valid(stage_valid), .stage_rd(stage_rd), .stage_wr(stage_wr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference view of an instruction: which sources it reads, whether it writes, legality.
  typedef struct packed {
    logic       ill;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } info_t;

  function automatic info_t ref_decode(input logic [31:0] ins);
    info_t i;
    logic [6:0] opc;
    logic legal, writes;
    opc   = ins[6:0];
    i.rd  = ins[11:7];
    i.rs1 = ins[19:15];
    i.rs2 = ins[24:20];
    legal = (opc == op_lui) || (opc == op_auipc) || (opc == op_jal) || (opc == op_jalr) ||
            (opc == op_br) || (opc == op_load) || (opc == op_store) || (opc == op_imm) ||
            ((opc == op_reg) && (ins[31:25] == 7'h00 || ins[31:25] == 7'h20));
    writes = (opc == op_lui) || (opc == op_auipc) || (opc == op_jal) || (opc == op_jalr) ||
             (opc == op_load) || (opc == op_imm) || (opc == op_reg);
    i.ill = !legal;
    i.wr  = legal && writes && (i.rd != 5'd0);
    i.mr  = legal && (opc == op_load);
    i.u1  = legal && ((opc == op_reg) || (opc == op_imm) || (opc == op_load) ||
                      (opc == op_store) || (opc == op_br) || (opc == op_jalr));
    i.u2  = legal && ((opc == op_reg) || (opc == op_store) || (opc == op_br));
    return i;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, r1, r2;
    rd = 5'($urandom_range(0, 3));
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0, 1:    return {12'h004, r1, 3'b010, rd, op_load};
      2:       return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, r2, r1, 3'b000, rd, op_reg};
      3:       return {12'h007, r1, 3'b000, rd, op_imm};
      4:       return {7'h00, r2, r1, 3'b010, 5'd0, op_store};
      5:       return {7'h00, r2, r1, 3'b000, 5'd0, op_br};
      6:       return {12'h000, r1, 3'b000, rd, op_jalr};
      default: return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : {20'h00001, rd, op_lui};
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  aluop;
    logic [2:0]  mux2;
    logic [2:0]  rfmux;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t   vecs[12];
  info_t  m_info[S];
  logic   m_vld[S];
  info_t  cur;
  logic   exp_hz, exp_rdy;
  logic [S-1:0]   exp_v, exp_w;
  logic [5*S-1:0] exp_rd, rd_mask;

  initial begin
    vecs[0]  = '{32'h002081B3, alu_add, mux2_rs2,   rf_alu_out,  5'd3,  1'b1, 1'b0};
    vecs[1]  = '{32'h402081B3, alu_sub, mux2_rs2,   rf_alu_out,  5'd3,  1'b1, 1'b0};
    vecs[2]  = '{32'h4040D193, alu_sra, mux2_i_imm, rf_alu_out,  5'd3,  1'b1, 1'b0};
    vecs[3]  = '{32'h0040D193, alu_srl, mux2_i_imm, rf_alu_out,  5'd3,  1'b1, 1'b0};
    vecs[4]  = '{32'h0050A193, 3'b010,  mux2_i_imm, rf_br_en,    5'd3,  1'b1, 1'b0};
    vecs[5]  = '{32'h0020B233, 3'b011,  mux2_rs2,   rf_br_en,    5'd4,  1'b1, 1'b0};
    vecs[6]  = '{32'h00002003, alu_add, mux2_i_imm, rf_load,     5'd0,  1'b0, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 3'b000,  3'd0,       3'd0,        5'd31, 1'b0, 1'b1};
    vecs[8]  = '{32'h202081B3, 3'b000,  3'd0,       3'd0,        5'd3,  1'b0, 1'b1};
    vecs[9]  = '{32'h000000EF, alu_add, mux2_j_imm, rf_pc_plus4, 5'd1,  1'b1, 1'b0};
    vecs[10] = '{32'h123453B7, alu_add, mux2_u_imm, rf_u_imm,    5'd7,  1'b1, 1'b0};
    vecs[11] = '{32'h0020A023, alu_add, mux2_s_imm, rf_alu_out,  5'd0,  1'b0, 1'b0};

    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; stall_in = 1'b0; flush = 1'b0;
    step(); step();
    chk("reset_valid", 64'(stage_valid), 64'd0);
    chk("reset_rd", 64'(stage_rd), 64'd0);
    chk("reset_wr", 64'(stage_wr), 64'd0);
    chk("reset_illegal", 64'(illegal), 64'd0);
    chk("reset_ctrl", 64'(ex_ctrl), 64'd0);
    rst_n = 1'b1;

    // back-to-back decode vectors, one per cycle
    for (int v = 0; v < 12; v++) begin
      id_valid = 1'b1; id_instr = vecs[v].instr;
      #1;
      chk($sformatf("vec%0d_ready", v), 64'(id_ready), 64'd1);
      step();
      chk($sformatf("vec%0d_valid", v), 64'(stage_valid[0]), 64'd1);
      chk($sformatf("vec%0d_illegal", v), 64'(illegal), 64'(vecs[v].ill));
      chk($sformatf("vec%0d_aluop", v), 64'(ex_ctrl.aluop), 64'(vecs[v].aluop));
      chk($sformatf("vec%0d_mux2", v), 64'(ex_ctrl.alumux2_sel), 64'(vecs[v].mux2));
      chk($sformatf("vec%0d_rfmux", v), 64'(ex_ctrl.regfilemux_sel), 64'(vecs[v].rfmux));
      chk($sformatf("vec%0d_rd", v), 64'(stage_rd[4:0]), 64'(vecs[v].rd));
      chk($sformatf("vec%0d_wr", v), 64'(stage_wr[0]), 64'(vecs[v].wr));
      if (vecs[v].ill) chk($sformatf("vec%0d_ctrl_zero", v), 64'(ex_ctrl), 64'd0);
    end

    // latency: add accepted, then travels to stage 2 two cycles later
    id_instr = 32'h002081B3;
    step();
    id_valid = 1'b0;
    chk("lat_s0", 64'(stage_valid[0]), 64'd1);
    step(); step();
    chk("lat_s2_valid", 64'(stage_valid[2:0]), 64'b100);
    chk("lat_s2_rd", 64'(stage_rd[14:10]), 64'd3);
    chk("lat_s2_wr", 64'(stage_wr[2]), 64'd1);

    // load-use: lw x5,0(x1) followed by add x6,x5,x1
    id_valid = 1'b1; id_instr = 32'h0000A283;
    #1;
    chk("lu_lw_ready", 64'(id_ready), 64'd1);
    step();
    id_instr = 32'h00128333;
    #1;
    chk("lu_hazard", 64'(hazard_stall), 64'd1);
    chk("lu_not_ready", 64'(id_ready), 64'd0);
    step();
    chk("lu_bubble", 64'(stage_valid[1:0]), 64'b10);
    chk("lu_hazard_gone", 64'(hazard_stall), 64'd0);
    chk("lu_ready_again", 64'(id_ready), 64'd1);
    step();
    id_valid = 1'b0;
    chk("lu_add_in", 64'(stage_valid[2:0]), 64'b101);
    chk("lu_add_rd", 64'(stage_rd[4:0]), 64'd6);

    // fill all stages with add x1..x4, then stall with flush pending
    for (int r = 1; r <= 4; r++) begin
      id_valid = 1'b1; id_instr = {7'h00, 5'd0, 5'd0, 3'b000, 5'(r), op_reg};
      step();
    end
    id_instr = {7'h00, 5'd0, 5'd0, 3'b000, 5'd5, op_reg};
    stall_in = 1'b1; flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_ready", c), 64'(id_ready), 64'd0);
      step();
      chk($sformatf("stall%0d_valid", c), 64'(stage_valid), 64'hF);
      chk($sformatf("stall%0d_rd", c), 64'(stage_rd), 64'({5'd1, 5'd2, 5'd3, 5'd4}));
      chk($sformatf("stall%0d_aluop", c), 64'(ex_ctrl.aluop), 64'(alu_add));
    end
    stall_in = 1'b0;
    #1;
    chk("flush_ready", 64'(id_ready), 64'd0);
    step();
    flush = 1'b0;
    chk("flush_valid", 64'(stage_valid), 64'hE);
    chk("flush_rd", 64'(stage_rd[19:5]), 64'({5'd2, 5'd3, 5'd4}));
    chk("flush_wr", 64'(stage_wr), 64'hE);

    // reset mid-stream
    id_instr = 32'h002081B3;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(stage_valid), 64'd0);
    chk("mid_rst_wr", 64'(stage_wr), 64'd0);
    step();
    id_valid = 1'b0;
    chk("post_rst_accept", 64'(stage_valid), 64'd1);
    chk("post_rst_rd", 64'(stage_rd[4:0]), 64'd3);

    // random traffic against the reference model
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < S; k++) begin m_vld[k] = 1'b0; m_info[k] = '0; end
    for (int c = 0; c < 400; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_instr = rand_instr();
      stall_in = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      #1;
      cur     = ref_decode(id_instr);
      exp_hz  = id_valid && m_vld[0] && m_info[0].mr &&
                ((cur.u1 && cur.rs1 != 5'd0 && cur.rs1 == m_info[0].rd) ||
                 (cur.u2 && cur.rs2 != 5'd0 && cur.rs2 == m_info[0].rd));
      exp_rdy = !stall_in && !exp_hz && !flush;
      chk("rnd_hazard", 64'(hazard_stall), 64'(exp_hz));
      chk("rnd_ready", 64'(id_ready), 64'(exp_rdy));
      if (!stall_in) begin
        for (int k = S - 1; k > 0; k--) begin
          m_vld[k]  = m_vld[k-1];
          m_info[k] = m_info[k-1];
        end
        m_vld[0]  = id_valid && exp_rdy;
        m_info[0] = cur;
      end
      step();
      exp_v = '0; exp_w = '0; exp_rd = '0; rd_mask = '0;
      for (int k = 0; k < S; k++) begin
        exp_v[k] = m_vld[k];
        exp_w[k] = m_vld[k] && m_info[k].wr;
        if (m_vld[k]) begin
          exp_rd[5*k +: 5]  = m_info[k].rd;
          rd_mask[5*k +: 5] = 5'h1F;
        end
      end
      chk("rnd_valid", 64'(stage_valid), 64'(exp_v));
      chk("rnd_wr", 64'(stage_wr), 64'(exp_w));
      chk("rnd_rd", 64'(stage_rd & rd_mask), 64'(exp_rd));
      chk("rnd_illegal", 64'(illegal), 64'(m_vld[0] && m_info[0].ill));
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
